// File: rtl/sha_block_sequencer.sv
// sha_block_sequencer: sequences the three SHA-256 blocks of one nonce attempt and owns the nonce/auto-run loop.
module sha_block_sequencer #(
  parameter int ROUNDS = 64,
  parameter int NONCE_W = 32,
  localparam int RW = $clog2(ROUNDS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               auto_run,
  input  logic               nonce_load,
  input  logic [NONCE_W-1:0] nonce_init,
  input  logic               digest_hit,
  output logic [1:0]         block_code,
  output logic [RW-1:0]      round,
  output logic               round_en,
  output logic               wv_init,
  output logic [1:0]         msg_sel,
  output logic [NONCE_W-1:0] nonce,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic               nonce_wrap
);
  typedef enum logic [2:0] {IDLE, LOAD, ROUND, ACCUM, DONE} state_t;
  localparam logic [RW-1:0] LAST = RW'(ROUNDS - 1);
  state_t r_state, w_state;
  logic [1:0] r_blk, w_blk, r_code, w_code, r_msg, w_msg;
  logic [RW-1:0] r_round, w_round;
  logic r_round_en, w_round_en, r_wv, w_wv, r_busy, r_done, w_done, r_found, w_found, r_wrap, w_wrap;
  logic [NONCE_W-1:0] r_nonce, w_nonce;
  always_comb begin
    w_state = r_state;
    w_blk = r_blk;
    w_code = r_code;
    w_msg = r_msg;
    w_round = r_round;
    w_round_en = 1'b0;
    w_wv = 1'b0;
    w_nonce = r_nonce;
    w_done = 1'b0;
    w_found = r_found;
    w_wrap = 1'b0;
    case (r_state)
      IDLE: begin
        if (nonce_load) w_nonce = nonce_init;
        if (start) begin
          w_state = LOAD;
          w_blk = 2'd0;
          w_code = 2'd0;
          w_msg = 2'd0;
          w_found = 1'b0;
          w_wv = 1'b1;
          w_round = '0;
        end
      end
      LOAD: begin
        w_state = ROUND;
        w_round_en = 1'b1;
        w_round = '0;
      end
      ROUND: begin
        w_state = (r_round == LAST) ? ACCUM : ROUND;
        w_code = (r_round == LAST) ? r_blk + 2'd1 : r_code;
        w_round = (r_round == LAST) ? '0 : r_round + RW'(1);
        w_round_en = (r_round != LAST);
      end
      ACCUM: begin
        if (r_blk < 2'd2) begin
          w_state = LOAD;
          w_blk = r_blk + 2'd1;
          w_msg = r_msg + 2'd1;
          w_wv = 1'b1;
          w_round = '0;
        end else begin
          w_state = DONE;
          w_done = 1'b1;
        end
      end
      DONE: begin
        if (digest_hit) begin
          w_found = 1'b1;
          w_state = IDLE;
        end else begin
          w_nonce = r_nonce + NONCE_W'(1);
          w_wrap = &r_nonce;
          w_state = auto_run ? LOAD : IDLE;
          w_blk = 2'd0;
          w_code = auto_run ? 2'd0 : r_code;
          w_msg = auto_run ? 2'd0 : r_msg;
          w_wv = auto_run;
        end
      end
      default: w_state = IDLE;
    endcase
    // abort wins over everything except reset, and suppresses the done pulse
    if (abort && r_state != IDLE) begin
      w_state = IDLE;
      w_blk = 2'd0;
      w_code = 2'd0;
      w_round = '0;
      w_round_en = 1'b0;
      w_wv = 1'b0;
      w_done = 1'b0;
      w_nonce = r_nonce;
      w_wrap = 1'b0;
      w_found = r_found;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_blk <= 2'd0;
      r_code <= 2'd0;
      r_msg <= 2'd0;
      r_round <= '0;
      r_round_en <= 1'b0;
      r_wv <= 1'b0;
      r_nonce <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_found <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_state <= w_state;
      r_blk <= w_blk;
      r_code <= w_code;
      r_msg <= w_msg;
      r_round <= w_round;
      r_round_en <= w_round_en;
      r_wv <= w_wv;
      r_nonce <= w_nonce;
      r_busy <= (w_state != IDLE);
      r_done <= w_done;
      r_found <= w_found;
      r_wrap <= w_wrap;
    end
  end
  assign block_code = r_code;
  assign round = r_round;
  assign round_en = r_round_en;
  assign wv_init = r_wv;
  assign msg_sel = r_msg;
  assign nonce = r_nonce;
  assign busy = r_busy;
  assign done = r_done;
  assign found = r_found;
  assign nonce_wrap = r_wrap;
endmodule

// File: tb/tb_sha_block_sequencer.sv
// tb_sha_block_sequencer: directed scenario tasks for the double SHA-256 block sequencer.
module tb_sha_block_sequencer;
  logic clk = 1'b0;
  logic rst_n, start, abort, auto_run, nonce_load, digest_hit;
  logic [31:0] nonce_init;
  logic [1:0] block_code, msg_sel;
  logic [5:0] round;
  logic round_en, wv_init, busy, done, found, nonce_wrap;
  logic [31:0] nonce;
  int errors = 0;
  int checks = 0;
  sha_block_sequencer #(.ROUNDS(64), .NONCE_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .auto_run(auto_run),
    .nonce_load(nonce_load), .nonce_init(nonce_init), .digest_hit(digest_hit),
    .block_code(block_code), .round(round), .round_en(round_en), .wv_init(wv_init),
    .msg_sel(msg_sel), .nonce(nonce), .busy(busy), .done(done), .found(found),
    .nonce_wrap(nonce_wrap)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // returns the attempt cycle index (accepting edge = 0) at which done is seen, or 400 on timeout
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (done !== 1'b1 && n < 400) begin
      tick;
      n++;
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; auto_run = 1'b0;
    nonce_load = 1'b0; nonce_init = 32'h0; digest_hit = 1'b0;
    tick;
    tick;
    checks++;
    if ({block_code, round, round_en, wv_init, msg_sel, nonce, busy, done, found, nonce_wrap} !== 48'h0) begin
      errors++;
      $display("FAIL reset_outputs: got code=%0d round=%0d nonce=%h busy=%b expected all zero", block_code, round, nonce, busy);
    end
    rst_n = 1'b1;
    tick;
  endtask
  task automatic test_timing;
    int rnd_err = 0, both_err = 0, early = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if ({wv_init, busy, round_en, round} !== {1'b1, 1'b1, 1'b0, 6'd0}) begin
      errors++;
      $display("FAIL load_cycle: got wv=%b busy=%b ren=%b round=%0d expected 1 1 0 0", wv_init, busy, round_en, round);
    end
    for (int c = 2; c <= 200; c++) begin
      tick;
      if (c <= 65 && (round_en !== 1'b1 || round !== 6'(c - 2))) rnd_err++;
      if (round_en && wv_init) both_err++;
      if (c < 199 && done !== 1'b0) early++;
      if (c == 66) begin
        checks++;
        if ({block_code, round_en} !== {2'd1, 1'b0}) begin
          errors++;
          $display("FAIL accum1: got code=%0d ren=%b expected 1 0", block_code, round_en);
        end
      end
      if (c == 67) begin
        checks++;
        if ({wv_init, msg_sel, block_code} !== {1'b1, 2'd1, 2'd1}) begin
          errors++;
          $display("FAIL load2: got wv=%b msg=%0d code=%0d expected 1 1 1", wv_init, msg_sel, block_code);
        end
      end
      if (c == 131 || c == 132) begin
        checks++;
        if (block_code !== 2'(c - 130)) begin
          errors++;
          $display("FAIL code_c%0d: got %0d expected %0d", c, block_code, c - 130);
        end
      end
      if (c == 198) begin
        checks++;
        if ({block_code, msg_sel} !== {2'd3, 2'd2}) begin
          errors++;
          $display("FAIL accum3: got code=%0d msg=%0d expected 3 2", block_code, msg_sel);
        end
      end
      if (c == 199) begin
        checks++;
        if ({done, busy} !== 2'b11) begin
          errors++;
          $display("FAIL done_199: got done=%b busy=%b expected 1 1", done, busy);
        end
      end
      if (c == 200) begin
        checks++;
        if ({done, busy, block_code, nonce} !== {2'b00, 2'd3, 32'd1}) begin
          errors++;
          $display("FAIL idle_200: got done=%b busy=%b code=%0d nonce=%h expected 0 0 3 1", done, busy, block_code, nonce);
        end
      end
    end
    checks++;
    if (rnd_err != 0 || both_err != 0 || early != 0) begin
      errors++;
      $display("FAIL round_seq: got rnd_err=%0d overlap=%0d early_done=%0d expected 0 0 0", rnd_err, both_err, early);
    end
  endtask
  task automatic test_nonce_load;
    int n;
    nonce_load = 1'b1; nonce_init = 32'h0000_1234; start = 1'b1;
    tick;
    nonce_load = 1'b0; start = 1'b0;
    checks++;
    if (nonce !== 32'h0000_1234) begin
      errors++;
      $display("FAIL nonce_load: got %h expected 00001234", nonce);
    end
    wait_done(1, n);
    tick;
    checks++;
    if ({n, nonce, found, busy} !== {32'd199, 32'h0000_1235, 2'b00}) begin
      errors++;
      $display("FAIL miss_inc: got at=%0d nonce=%h found=%b busy=%b expected 199 00001235 0 0", n, nonce, found, busy);
    end
  endtask
  task automatic test_auto_run;
    int n;
    auto_run = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_done(1, n);
      checks++;
      if (n != 199) begin
        errors++;
        $display("FAIL auto_period%0d: got %0d expected 199", k, n);
      end
      if (k == 2) digest_hit = 1'b1;
      tick;
      if (k == 0) begin
        checks++;
        if ({busy, wv_init, block_code, msg_sel} !== {2'b11, 2'd0, 2'd0}) begin
          errors++;
          $display("FAIL auto_restart: got busy=%b wv=%b code=%0d msg=%0d expected 1 1 0 0", busy, wv_init, block_code, msg_sel);
        end
      end
    end
    digest_hit = 1'b0; auto_run = 1'b0;
    checks++;
    if ({nonce, found, busy, block_code} !== {32'h0000_1237, 2'b10, 2'd3}) begin
      errors++;
      $display("FAIL auto_hit: got nonce=%h found=%b busy=%b code=%0d expected 00001237 1 0 3", nonce, found, busy, block_code);
    end
  endtask
  task automatic test_wrap;
    int n;
    nonce_load = 1'b1; nonce_init = 32'hFFFF_FFFF; start = 1'b1;
    tick;
    nonce_load = 1'b0; start = 1'b0;
    checks++;
    if ({found, block_code} !== {1'b0, 2'd0}) begin
      errors++;
      $display("FAIL start_clear: got found=%b code=%0d expected 0 0", found, block_code);
    end
    wait_done(1, n);
    checks++;
    if ({done, nonce_wrap} !== 2'b10) begin
      errors++;
      $display("FAIL wrap_pre: got done=%b wrap=%b expected 1 0", done, nonce_wrap);
    end
    tick;
    checks++;
    if ({nonce, nonce_wrap, done} !== {32'h0, 2'b10}) begin
      errors++;
      $display("FAIL wrap: got nonce=%h wrap=%b done=%b expected 00000000 1 0", nonce, nonce_wrap, done);
    end
    tick;
    checks++;
    if (nonce_wrap !== 1'b0) begin
      errors++;
      $display("FAIL wrap_pulse: got %b expected 0", nonce_wrap);
    end
  endtask
  task automatic test_abort;
    int n, seen = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (97) tick;
    checks++;
    if ({round, block_code, msg_sel, round_en} !== {6'd30, 2'd1, 2'd1, 1'b1}) begin
      errors++;
      $display("FAIL pre_abort: got round=%0d code=%0d msg=%0d expected 30 1 1", round, block_code, msg_sel);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if ({busy, block_code, round, round_en, wv_init, nonce} !== {1'b0, 2'd0, 6'd0, 2'b00, 32'h0}) begin
      errors++;
      $display("FAIL abort: got busy=%b code=%0d round=%0d ren=%b nonce=%h expected 0 0 0 0 0", busy, block_code, round, round_en, nonce);
    end
    repeat (250) begin
      tick;
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_quiet: got %0d active cycles expected 0", seen);
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(1, n);
    tick;
    checks++;
    if ({n, nonce} !== {32'd199, 32'd1}) begin
      errors++;
      $display("FAIL restart: got at=%0d nonce=%h expected 199 00000001", n, nonce);
    end
  endtask
  task automatic test_back_to_back;
    int n;
    start = 1'b1;
    tick;
    repeat (143) tick;
    rst_n = 1'b0;
    tick;
    checks++;
    if ({block_code, round, round_en, wv_init, msg_sel, nonce, busy, done, found, nonce_wrap} !== 48'h0) begin
      errors++;
      $display("FAIL mid_reset: got code=%0d round=%0d ren=%b nonce=%h busy=%b expected all zero", block_code, round, round_en, nonce, busy);
    end
    rst_n = 1'b1;
    tick;
    checks++;
    if ({busy, wv_init} !== 2'b11) begin
      errors++;
      $display("FAIL held_start: got busy=%b wv=%b expected 1 1", busy, wv_init);
    end
    repeat (149) tick;
    start = 1'b0;
    wait_done(150, n);
    tick;
    checks++;
    if ({n, busy, nonce} !== {32'd199, 1'b0, 32'd1}) begin
      errors++;
      $display("FAIL busy_start: got at=%0d busy=%b nonce=%h expected 199 0 00000001", n, busy, nonce);
    end
  endtask
  initial begin
    test_reset;
    test_timing;
    test_nonce_load;
    test_auto_run;
    test_wrap;
    test_abort;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
